ethernet_packet_generator: RTL and testbench

ETHERNET_PACKET_GENERATOR -- requirements
Module: ethernet_packet_generator

---
 rtl/ethernet_packet_generator.sv | 142 ++++++++++++++
 tb/tb_ethernet_packet_generator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_packet_generator.sv
// ethernet_packet_generator: Ethernet frame serializer; define ETHERNET_PACKET_GENERATOR_FCS_EN to append CRC-32 FCS
module ethernet_packet_generator #(
    parameter int MIN_PAYLOAD_BYTES = 46,
    parameter int MAX_PAYLOAD_BYTES = 1500,
    parameter int INTER_PACKET_GAP  = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [47:0] destination_mac,
    input  logic [47:0] source_mac,
    input  logic [15:0] ether_type,
    input  logic        start,
    input  logic [7:0]  payload_data,
    input  logic        payload_data_valid,
    input  logic        payload_data_last,
    output logic        payload_data_ready,
    output logic [7:0]  data,
    output logic        data_enable,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_error
);
    localparam logic [10:0] MIN_C = 11'(MIN_PAYLOAD_BYTES);
    localparam logic [10:0] MAX_C = 11'(MAX_PAYLOAD_BYTES);
    localparam logic [10:0] IPG_C = 11'(INTER_PACKET_GAP);
    typedef enum logic [3:0] {
        S_IDLE, S_PREAMBLE, S_START_OF_FRAME, S_MAC_DESTINATION, S_MAC_SOURCE,
        S_ETHER_TYPE, S_PAYLOAD, S_PADDING, S_FCS, S_GAP
    } state_t;
    state_t state, state_n, end_state;
    logic [10:0] cnt, cnt_n, cnt_inc;
    logic [47:0] dst, src;
    logic [15:0] etype;
    logic [7:0] byte_n, fcs_byte;
    logic en_n, err_n, done_n;
    logic [2:0] mac_idx;
    assign cnt_inc = cnt + 11'd1;
    assign mac_idx = 3'd5 - cnt[2:0];
    assign busy = state != S_IDLE;
    assign payload_data_ready = reset_n && state == S_PAYLOAD;
`ifdef ETHERNET_PACKET_GENERATOR_FCS_EN
    logic [31:0] crc, crc_n, fcs;
    assign end_state = S_FCS;
    assign fcs = ~crc;
    assign fcs_byte = fcs[{cnt[1:0], 3'b000} +: 8];
    always_comb begin
        crc_n = crc;
        for (int i = 0; i < 8; i++)
            crc_n = {1'b0, crc_n[31:1]} ^ ((crc_n[0] ^ byte_n[i]) ? 32'hEDB88320 : 32'h0);
    end
    always_ff @(posedge clock) begin
        if (!reset_n || state == S_IDLE)
            crc <= '1;
        else if (en_n && state inside {S_MAC_DESTINATION, S_MAC_SOURCE, S_ETHER_TYPE, S_PAYLOAD, S_PADDING})
            crc <= crc_n;
    end
`else
    assign end_state = S_GAP;
    assign fcs_byte = 8'h00;
`endif
    always_comb begin
        state_n = state;
        byte_n = 8'h00;
        en_n = 1'b0;
        err_n = 1'b0;
        case (state)
            S_IDLE: state_n = start ? S_PREAMBLE : S_IDLE;
            S_PREAMBLE: begin
                byte_n = 8'h55;
                en_n = 1'b1;
                if (cnt == 11'd6) state_n = S_START_OF_FRAME;
            end
            S_START_OF_FRAME: begin
                byte_n = 8'hD5;
                en_n = 1'b1;
                state_n = S_MAC_DESTINATION;
            end
            S_MAC_DESTINATION: begin
                byte_n = dst[{mac_idx, 3'b000} +: 8];
                en_n = 1'b1;
                if (cnt == 11'd5) state_n = S_MAC_SOURCE;
            end
            S_MAC_SOURCE: begin
                byte_n = src[{mac_idx, 3'b000} +: 8];
                en_n = 1'b1;
                if (cnt == 11'd5) state_n = S_ETHER_TYPE;
            end
            S_ETHER_TYPE: begin
                byte_n = cnt[0] ? etype[7:0] : etype[15:8];
                en_n = 1'b1;
                if (cnt[0]) state_n = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                byte_n = payload_data_valid ? payload_data : 8'h00;
                en_n = payload_data_valid;
                err_n = !payload_data_valid || (!payload_data_last && cnt_inc == MAX_C);
                if (!payload_data_valid)
                    state_n = S_GAP;
                else if (payload_data_last || cnt_inc == MAX_C)
                    state_n = cnt_inc < MIN_C ? S_PADDING : end_state;
            end
            S_PADDING: begin
                en_n = 1'b1;
                if (cnt_inc == MIN_C) state_n = end_state;
            end
            S_FCS: begin
                byte_n = fcs_byte;
                en_n = 1'b1;
                if (cnt == 11'd3) state_n = S_GAP;
            end
            S_GAP: if (cnt == IPG_C - 11'd1) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // padding continues the payload count so it stops at the minimum length
        cnt_n = (busy && (state_n == state || state_n == S_PADDING)) ? cnt_inc : '0;
        done_n = en_n && state_n == S_GAP;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt <= '0;
            data <= 8'h00;
            data_enable <= 1'b0;
            frame_done <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            data <= byte_n;
            data_enable <= en_n;
            frame_done <= done_n;
            frame_error <= err_n;
        end
    end
    always_ff @(posedge clock) begin
        if (reset_n && state == S_IDLE && start) begin
            dst <= destination_mac;
            src <= source_mac;
            etype <= ether_type;
        end
    end
endmodule

// File: tb/tb_ethernet_packet_generator.sv
// tb_ethernet_packet_generator: directed tests for ethernet_packet_generator
module tb_ethernet_packet_generator;
    localparam logic [47:0] DST = 48'h112233445566;
    localparam logic [47:0] SRC = 48'hA1B2C3D4E5F6;
    localparam logic [15:0] ET = 16'h0800;
`ifdef ETHERNET_PACKET_GENERATOR_FCS_EN
    localparam int FCS_LEN = 4;
`else
    localparam int FCS_LEN = 0;
`endif
    typedef logic [7:0] bq_t [$];
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [47:0] destination_mac = DST;
    logic [47:0] source_mac = SRC;
    logic [15:0] ether_type = ET;
    logic start = 1'b0;
    logic [7:0] payload_data = 8'h00;
    logic payload_data_valid = 1'b0;
    logic payload_data_last = 1'b0;
    logic payload_data_ready, data_enable, busy, frame_done, frame_error;
    logic [7:0] data;
    int passed = 0;
    int total = 0;
    logic [7:0] pay [0:1599];
    bq_t cap;
    int done_tot = 0, err_tot = 0, rise_tot = 0, gap_tot = 0, viol_tot = 0;
    logic prev_de = 1'b0;
    logic in_gap = 1'b0;
    logic r_de0, r_busy0, r_de1;
    logic [7:0] r_d1;
    int r_acc, r_done, r_err, r_rise, r_gap, r_viol;
    bit r_to;
    bq_t r_got, exp_q;

    ethernet_packet_generator dut (
        .clock(clock), .reset_n(reset_n), .destination_mac(destination_mac),
        .source_mac(source_mac), .ether_type(ether_type), .start(start),
        .payload_data(payload_data), .payload_data_valid(payload_data_valid),
        .payload_data_last(payload_data_last), .payload_data_ready(payload_data_ready),
        .data(data), .data_enable(data_enable), .busy(busy),
        .frame_done(frame_done), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (data_enable === 1'b1) cap.push_back(data);
        if (data_enable === 1'b1 && prev_de !== 1'b1) rise_tot++;
        if (data_enable === 1'b0 && data !== 8'h00) viol_tot++;
        if (frame_done === 1'b1) done_tot++;
        if (frame_error === 1'b1) err_tot++;
        if (frame_done === 1'b1 || (frame_error === 1'b1 && data_enable === 1'b0)) in_gap = 1'b1;
        if (in_gap && busy === 1'b1) gap_tot++;
        if (busy !== 1'b1) in_gap = 1'b0;
        prev_de = data_enable;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

`ifdef ETHERNET_PACKET_GENERATOR_FCS_EN
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction
`endif

    task automatic build_exp(input int n, output bq_t e);
        logic [31:0] c;
        e.delete();
        repeat (7) e.push_back(8'h55);
        e.push_back(8'hD5);
        for (int i = 0; i < 6; i++) e.push_back(DST[47 - 8 * i -: 8]);
        for (int i = 0; i < 6; i++) e.push_back(SRC[47 - 8 * i -: 8]);
        e.push_back(ET[15:8]);
        e.push_back(ET[7:0]);
        for (int i = 0; i < n; i++) e.push_back(pay[i]);
        for (int i = n; i < 46; i++) e.push_back(8'h00);
        c = '1;
`ifdef ETHERNET_PACKET_GENERATOR_FCS_EN
        for (int i = 8; i < e.size(); i++) c = crc_byte(c, e[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) e.push_back(c[8 * i +: 8]);
`endif
    endtask

    function automatic int first_diff(input bq_t a, input bq_t b);
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic send(input int n, input bit last_en, input int valid_for, input bit poke);
        int base_q, b_done, b_err, b_rise, b_gap, b_viol;
        bit poked, rdy;
        base_q = cap.size();
        b_done = done_tot; b_err = err_tot; b_rise = rise_tot; b_gap = gap_tot; b_viol = viol_tot;
        start = 1'b1;
        tick();
        start = 1'b0;
        r_de0 = data_enable;
        r_busy0 = busy;
        tick();
        r_de1 = data_enable;
        r_d1 = data;
        r_acc = 0;
        poked = 0;
        r_to = 1;
        for (int c = 0; c < 4000; c++) begin
            payload_data = r_acc < 1600 ? pay[r_acc] : 8'h00;
            payload_data_valid = r_acc < valid_for;
            payload_data_last = last_en && r_acc == n - 1;
            rdy = payload_data_ready;
            start = poke && !poked && rdy && r_acc == 5;
            if (start) poked = 1;
            tick();
            start = 1'b0;
            if (rdy && payload_data_valid) r_acc++;
            if (!busy) begin
                r_to = 0;
                break;
            end
        end
        payload_data_valid = 1'b0;
        payload_data_last = 1'b0;
        r_got.delete();
        for (int i = base_q; i < cap.size(); i++) r_got.push_back(cap[i]);
        r_done = done_tot - b_done; r_err = err_tot - b_err; r_rise = rise_tot - b_rise;
        r_gap = gap_tot - b_gap; r_viol = viol_tot - b_viol;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total++; if (data_enable !== 1'b0) $display("FAIL reset_de: got %b want 0", data_enable); else passed++;
        total++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (frame_done !== 1'b0 || frame_error !== 1'b0) $display("FAIL reset_pulses: got %b%b want 00", frame_done, frame_error); else passed++;
        total++; if (payload_data_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", payload_data_ready); else passed++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int d;
        for (int i = 0; i < 1600; i++) pay[i] = 8'(i);
        send(46, 1, 46, 0);
        build_exp(46, exp_q);
        d = first_diff(r_got, exp_q);
        total++; if (r_to) $display("FAIL basic_timeout: got busy stuck want idle"); else passed++;
        total++; if (r_de0 !== 1'b0 || r_busy0 !== 1'b1) $display("FAIL basic_start_edge: got de=%b busy=%b want de=0 busy=1", r_de0, r_busy0); else passed++;
        total++; if (r_de1 !== 1'b1 || r_d1 !== 8'h55) $display("FAIL basic_first_byte: got de=%b data=%h want 1 55", r_de1, r_d1); else passed++;
        total++; if (r_got.size() != 68 + FCS_LEN) $display("FAIL basic_len: got %0d want %0d", r_got.size(), 68 + FCS_LEN); else passed++;
        total++; if (d >= 0) $display("FAIL basic_bytes: at %0d got %h want %h", d, r_got[d], exp_q[d]); else passed++;
        total++; if (r_rise != 1) $display("FAIL basic_contiguous: got %0d bursts want 1", r_rise); else passed++;
        total++; if (r_done != 1 || r_err != 0) $display("FAIL basic_flags: got done=%0d err=%0d want 1 0", r_done, r_err); else passed++;
        total++; if (r_gap != 12) $display("FAIL basic_gap: got %0d want 12", r_gap); else passed++;
        total++; if (r_viol != 0) $display("FAIL basic_idle_data: got %0d nonzero idle bytes want 0", r_viol); else passed++;
    endtask

    task automatic test_padding();
        int d;
        logic [31:0] c;
        pay[0] = 8'hAB;
        send(1, 1, 1, 0);
        build_exp(1, exp_q);
        d = first_diff(r_got, exp_q);
        total++; if (r_got.size() != 68 + FCS_LEN) $display("FAIL pad_len: got %0d want %0d", r_got.size(), 68 + FCS_LEN); else passed++;
        total++; if (d >= 0) $display("FAIL pad_bytes: at %0d got %h want %h", d, r_got[d], exp_q[d]); else passed++;
        total++; if (r_done != 1 || r_err != 0 || r_acc != 1) $display("FAIL pad_flags: got done=%0d err=%0d acc=%0d want 1 0 1", r_done, r_err, r_acc); else passed++;
`ifdef ETHERNET_PACKET_GENERATOR_FCS_EN
        c = '1;
        for (int i = 8; i < r_got.size(); i++) c = crc_byte(c, r_got[i]);
        total++; if (c !== 32'hDEBB20E3) $display("FAIL pad_residue: got %h want debb20e3", c); else passed++;
`else
        c = '0;
`endif
        pay[0] = 8'h00;
    endtask

    task automatic test_underrun();
        send(46, 1, 10, 0);
        total++; if (r_to) $display("FAIL underrun_timeout: got busy stuck want idle"); else passed++;
        total++; if (r_got.size() != 32) $display("FAIL underrun_len: got %0d want 32", r_got.size()); else passed++;
        total++; if (r_got.size() > 0 && r_got[r_got.size() - 1] !== 8'h09) $display("FAIL underrun_last: got %h want 09", r_got[r_got.size() - 1]); else passed++;
        total++; if (r_err != 1 || r_done != 0) $display("FAIL underrun_flags: got err=%0d done=%0d want 1 0", r_err, r_done); else passed++;
        total++; if (r_gap != 12) $display("FAIL underrun_gap: got %0d want 12", r_gap); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL underrun_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_start_ignored();
        int sz;
        send(46, 1, 46, 1);
        total++; if (r_done != 1 || r_got.size() != 68 + FCS_LEN) $display("FAIL ign_frame1: got done=%0d len=%0d want 1 %0d", r_done, r_got.size(), 68 + FCS_LEN); else passed++;
        sz = cap.size();
        repeat (20) tick();
        total++; if (busy !== 1'b0 || cap.size() != sz) $display("FAIL ign_no_queue: got busy=%b bytes=%0d want 0 0", busy, cap.size() - sz); else passed++;
        send(46, 1, 46, 0);
        total++; if (r_de0 !== 1'b0 || r_de1 !== 1'b1 || r_d1 !== 8'h55) $display("FAIL ign_restart: got %b %b %h want 0 1 55", r_de0, r_de1, r_d1); else passed++;
        total++; if (r_got.size() != 68 + FCS_LEN) $display("FAIL ign_frame2_len: got %0d want %0d", r_got.size(), 68 + FCS_LEN); else passed++;
    endtask

    task automatic test_reset_mid();
        int base, d;
        bit hit;
        base = cap.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 40; c++) begin
            if (cap.size() - base >= 16) begin
                hit = 1;
                break;
            end
            tick();
        end
        total++; if (!hit) $display("FAIL midrst_reach_src: got %0d bytes want 16", cap.size() - base); else passed++;
        reset_n = 1'b0;
        tick();
        total++; if (data_enable !== 1'b0 || busy !== 1'b0 || data !== 8'h00) $display("FAIL midrst_trunc: got de=%b busy=%b data=%h want 0 0 00", data_enable, busy, data); else passed++;
        reset_n = 1'b1;
        tick();
        payload_data_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 40; c++) begin
            if (payload_data_ready) begin
                hit = 1;
                break;
            end
            tick();
        end
        reset_n = 1'b0;
        #1;
        total++; if (!hit || payload_data_ready !== 1'b0) $display("FAIL midrst_ready: got reached=%0d ready=%b want 1 0", hit, payload_data_ready); else passed++;
        tick();
        payload_data_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        send(20, 1, 20, 0);
        build_exp(20, exp_q);
        d = first_diff(r_got, exp_q);
        total++; if (r_de1 !== 1'b1 || r_d1 !== 8'h55 || r_got.size() != exp_q.size()) $display("FAIL midrst_next_len: got %0d want %0d", r_got.size(), exp_q.size()); else passed++;
        total++; if (d >= 0) $display("FAIL midrst_next_bytes: at %0d got %h want %h", d, r_got[d], exp_q[d]); else passed++;
    endtask

    task automatic test_max();
        int d;
        send(1600, 0, 1600, 0);
        build_exp(1500, exp_q);
        d = first_diff(r_got, exp_q);
        total++; if (r_acc != 1500) $display("FAIL max_accepted: got %0d want 1500", r_acc); else passed++;
        total++; if (r_got.size() != 1522 + FCS_LEN) $display("FAIL max_len: got %0d want %0d", r_got.size(), 1522 + FCS_LEN); else passed++;
        total++; if (d >= 0) $display("FAIL max_bytes: at %0d got %h want %h", d, r_got[d], exp_q[d]); else passed++;
        total++; if (r_err != 1 || r_done != 1) $display("FAIL max_flags: got err=%0d done=%0d want 1 1", r_err, r_done); else passed++;
        total++; if (r_gap != 12) $display("FAIL max_gap: got %0d want 12", r_gap); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 1600; i++) pay[i] = 8'(i);
        test_reset();
        test_basic();
        test_padding();
        test_underrun();
        test_start_ignored();
        test_reset_mid();
        test_max();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish within 200000 time units");
        $fatal(1);
    end
endmodule
